// File: rtl/axis_fir_pkg.sv
// Shared types and constants for the AXI-Stream FIR coefficient controller.
package axis_fir_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    DRAIN   = 2'd2,
    PENDING = 2'd3
  } state_t;

  localparam int SWAP_W = 8;

  // Index width for n entries; never narrower than one bit so N=1 still has a counter.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/axis_fir_coeff_bank.sv
// Shadow/active coefficient register pair; the active bank is the packed coeff_vector.
module axis_fir_coeff_bank
  import axis_fir_pkg::*;
#(
  parameter int filter_order      = 16,
  parameter int coefficient_width = 16,
  parameter int idx_w             = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      wr_en,
  input  logic [idx_w-1:0]                          wr_idx,
  input  logic [coefficient_width-1:0]              wr_data,
  input  logic                                      swap,
  output logic [filter_order*coefficient_width-1:0] coeff_vector
);

  logic [filter_order-1:0][coefficient_width-1:0] shadow;
  logic [filter_order-1:0][coefficient_width-1:0] active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (wr_en) shadow[wr_idx] <= wr_data;
      if (swap)  active <= shadow;
    end
  end

  // Element k of the packed array sits at [k*W +: W].
  assign coeff_vector = active;

endmodule

// File: rtl/axis_fir_coeff_ctrl.sv
// Coefficient controller: loads a shadow set over AXI-Stream, checks its length and
// swaps it in at a data-frame boundary. Option: AXIS_FIR_COEFF_IMMEDIATE_SWAP_EN.
module axis_fir_coeff_ctrl
  import axis_fir_pkg::*;
#(
  parameter int filter_order      = 16,
  parameter int coefficient_width = 16
) (
  input  logic                                      aclk,
  input  logic                                      reset,
  input  logic [coefficient_width-1:0]              s_axis_coeff_tdata,
  input  logic                                      s_axis_coeff_tvalid,
  input  logic                                      s_axis_coeff_tlast,
  output logic                                      s_axis_coeff_tready,
  input  logic                                      data_tvalid,
  input  logic                                      data_tready,
  input  logic                                      data_tlast,
  output logic [filter_order*coefficient_width-1:0] coeff_vector,
  output logic                                      coeff_pending,
  output logic                                      load_error,
  input  logic                                      error_clear,
  output logic [SWAP_W-1:0]                         swap_count
);

  localparam int              CNT_W    = clog2(filter_order);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(filter_order - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             beat;
  logic             boundary;
  logic             swap;
  logic             wr_en;

  assign beat     = s_axis_coeff_tvalid & s_axis_coeff_tready;
  assign boundary = data_tvalid & data_tready & data_tlast;
  assign wr_en    = beat && ((state == IDLE) || (state == LOAD));

`ifdef AXIS_FIR_COEFF_IMMEDIATE_SWAP_EN
  assign swap = (state == PENDING);
`else
  assign swap = (state == PENDING) && boundary;
`endif

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      cnt                 <= '0;
      s_axis_coeff_tready <= 1'b1;
      coeff_pending       <= 1'b0;
      load_error          <= 1'b0;
      swap_count          <= '0;
    end else begin
      // Clear first so any error set below in the same cycle takes precedence.
      if (error_clear) load_error <= 1'b0;
      case (state)
        IDLE: begin
          if (beat) begin
            if (s_axis_coeff_tlast) begin
              if (filter_order == 1) begin
                state               <= PENDING;
                s_axis_coeff_tready <= 1'b0;
                coeff_pending       <= 1'b1;
              end else begin
                load_error <= 1'b1;
              end
            end else if (filter_order == 1) begin
              load_error <= 1'b1;
              state      <= DRAIN;
            end else begin
              state <= LOAD;
              cnt   <= CNT_W'(1);
            end
          end
        end
        LOAD: begin
          if (beat) begin
            if (cnt == LAST_IDX) begin
              cnt <= '0;
              if (s_axis_coeff_tlast) begin
                state               <= PENDING;
                s_axis_coeff_tready <= 1'b0;
                coeff_pending       <= 1'b1;
              end else begin
                load_error <= 1'b1;
                state      <= DRAIN;
              end
            end else if (s_axis_coeff_tlast) begin
              load_error <= 1'b1;
              state      <= IDLE;
              cnt        <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (beat && s_axis_coeff_tlast) state <= IDLE;
        end
        PENDING: begin
          if (swap) begin
            state               <= IDLE;
            s_axis_coeff_tready <= 1'b1;
            coeff_pending       <= 1'b0;
            swap_count          <= swap_count + SWAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  axis_fir_coeff_bank #(
    .filter_order      (filter_order),
    .coefficient_width (coefficient_width),
    .idx_w             (CNT_W)
  ) u_bank (
    .clk          (aclk),
    .rst          (reset),
    .wr_en        (wr_en),
    .wr_idx       (cnt),
    .wr_data      (s_axis_coeff_tdata),
    .swap         (swap),
    .coeff_vector (coeff_vector)
  );

endmodule

// File: tb/tb_axis_fir_coeff_ctrl.sv
// Scoreboard bench for axis_fir_coeff_ctrl: stimulus queues expected swaps, a monitor checks them.
module tb_axis_fir_coeff_ctrl;

  localparam int N = 16;
  localparam int W = 16;

  typedef struct {
    logic [N*W-1:0] vec;
    logic [7:0]     cnt;
  } exp_t;

  logic           aclk = 1'b0;
  logic           reset;
  logic [W-1:0]   s_axis_coeff_tdata;
  logic           s_axis_coeff_tvalid;
  logic           s_axis_coeff_tlast;
  logic           s_axis_coeff_tready;
  logic           data_tvalid;
  logic           data_tready;
  logic           data_tlast;
  logic [N*W-1:0] coeff_vector;
  logic           coeff_pending;
  logic           load_error;
  logic           error_clear;
  logic [7:0]     swap_count;

  int             checks = 0;
  int             errors = 0;
  exp_t           q[$];
  logic [N*W-1:0] exp_active;

  axis_fir_coeff_ctrl #(.filter_order(N), .coefficient_width(W)) dut (
    .aclk                (aclk),
    .reset               (reset),
    .s_axis_coeff_tdata  (s_axis_coeff_tdata),
    .s_axis_coeff_tvalid (s_axis_coeff_tvalid),
    .s_axis_coeff_tlast  (s_axis_coeff_tlast),
    .s_axis_coeff_tready (s_axis_coeff_tready),
    .data_tvalid         (data_tvalid),
    .data_tready         (data_tready),
    .data_tlast          (data_tlast),
    .coeff_vector        (coeff_vector),
    .coeff_pending       (coeff_pending),
    .load_error          (load_error),
    .error_clear         (error_clear),
    .swap_count          (swap_count)
  );

  always #5 aclk = ~aclk;

  function automatic logic [N*W-1:0] mkvec(input int base);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(base + k);
    return v;
  endfunction

  task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_swap(input int base, input int cnt);
    exp_t e;
    e.vec = mkvec(base);
    e.cnt = 8'(cnt);
    exp_active = e.vec;
    q.push_back(e);
  endtask

  task automatic beat(input logic [W-1:0] d, input bit last, input bit clr);
    int t;
    s_axis_coeff_tdata  = d;
    s_axis_coeff_tvalid = 1'b1;
    s_axis_coeff_tlast  = last;
    error_clear         = clr;
    t = 0;
    while (!s_axis_coeff_tready && t < 100) begin
      @(posedge aclk); #1;
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout tready=%0b required=1", s_axis_coeff_tready);
    end
    @(posedge aclk); #1;
    s_axis_coeff_tvalid = 1'b0;
    s_axis_coeff_tlast  = 1'b0;
    error_clear         = 1'b0;
  endtask

  task automatic send(input int n, input int base, input bit clr_last);
    for (int k = 0; k < n; k++) beat(W'(base + k), k == n - 1, clr_last && (k == n - 1));
  endtask

  task automatic dbeat(input bit last);
    data_tvalid = 1'b1;
    data_tready = 1'b1;
    data_tlast  = last;
    @(posedge aclk); #1;
    data_tvalid = 1'b0;
    data_tready = 1'b0;
    data_tlast  = 1'b0;
  endtask

  // Monitor: every change of swap_count outside reset must match the next queued swap.
  initial begin : monitor
    logic [7:0] prev;
    exp_t       e;
    prev = 8'd0;
    forever begin
      @(negedge aclk);
      if (reset) begin
        prev = swap_count;
      end else if (swap_count !== prev) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_swap swap_count=%0d required=%0d", swap_count, prev);
        end else begin
          e = q.pop_front();
          chk("swap_count", N*W'(swap_count), N*W'(e.cnt));
          chk("swap_vector", coeff_vector, e.vec);
        end
        prev = swap_count;
      end
    end
  end

  initial begin : stim
    int t;
    reset = 1'b1;
    s_axis_coeff_tdata = '0; s_axis_coeff_tvalid = 1'b0; s_axis_coeff_tlast = 1'b0;
    data_tvalid = 1'b0; data_tready = 1'b0; data_tlast = 1'b0; error_clear = 1'b0;
    exp_active = '0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_vector", coeff_vector, '0);
    chk("rst_tready", N*W'(s_axis_coeff_tready), N*W'(1));
    chk("rst_pending", N*W'(coeff_pending), '0);
    chk("rst_error", N*W'(load_error), '0);
    chk("rst_swap_count", N*W'(swap_count), '0);
    reset = 1'b0;
    @(posedge aclk); #1;

`ifdef AXIS_FIR_COEFF_IMMEDIATE_SWAP_EN
    send(N, 1, 1'b0);
    chk("imm_pending_on", N*W'(coeff_pending), N*W'(1));
    chk("imm_vector_before", coeff_vector, '0);
    expect_swap(1, 1);
    @(posedge aclk); #1;
    chk("imm_pending_off", N*W'(coeff_pending), '0);
    chk("imm_vector_after", coeff_vector, mkvec(1));
    chk("imm_tready", N*W'(s_axis_coeff_tready), N*W'(1));
    for (int i = 2; i <= 256; i++) begin
      send(N, i, 1'b0);
      expect_swap(i, i);
      @(posedge aclk); #1;
    end
    chk("imm_wrap", N*W'(swap_count), '0);
`else
    // Valid 16-beat set, swapped in by a 4-beat data frame.
    send(N, 1, 1'b0);
    chk("t1_pending", N*W'(coeff_pending), N*W'(1));
    chk("t1_tready", N*W'(s_axis_coeff_tready), '0);
    chk("t1_vector_hold", coeff_vector, '0);
    dbeat(1'b0); dbeat(1'b0); dbeat(1'b0);
    chk("t1_no_early_swap", N*W'(swap_count), '0);
    expect_swap(1, 1);
    dbeat(1'b1);
    chk("t1_coef0", N*W'(coeff_vector[0 +: W]), N*W'(1));
    chk("t1_coef15", N*W'(coeff_vector[240 +: W]), N*W'(16));
    chk("t1_pending_off", N*W'(coeff_pending), '0);

    // A boundary while idle must not swap (the monitor flags any count change).
    dbeat(1'b1);

    // Short set with a simultaneous error_clear: error is set, active bank kept.
    send(10, 50, 1'b1);
    chk("t2_error", N*W'(load_error), N*W'(1));
    chk("t2_vector", coeff_vector, exp_active);
    chk("t2_pending", N*W'(coeff_pending), '0);
    chk("t2_tready", N*W'(s_axis_coeff_tready), N*W'(1));
    error_clear = 1'b1;
    @(posedge aclk); #1;
    error_clear = 1'b0;
    chk("t2_clear", N*W'(load_error), '0);

    // Long set: overflow is drained, then a correct set loads normally.
    send(20, 100, 1'b0);
    chk("t3_error", N*W'(load_error), N*W'(1));
    chk("t3_pending", N*W'(coeff_pending), '0);
    chk("t3_vector", coeff_vector, exp_active);
    error_clear = 1'b1;
    @(posedge aclk); #1;
    error_clear = 1'b0;
    send(N, 200, 1'b0);
    chk("t3_pending_ok", N*W'(coeff_pending), N*W'(1));
    expect_swap(200, 2);
    dbeat(1'b1);

    // Pending set held off while the data stream runs without tlast.
    send(N, 300, 1'b0);
    s_axis_coeff_tvalid = 1'b1;
    s_axis_coeff_tdata  = 16'hDEAD;
    data_tvalid = 1'b1; data_tready = 1'b1; data_tlast = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge aclk); #1;
      chk("t4_tready_low", N*W'(s_axis_coeff_tready), '0);
      chk("t4_vector_hold", coeff_vector, exp_active);
    end
    data_tready = 1'b0; data_tlast = 1'b1;
    @(posedge aclk); #1;
    chk("t4_no_swap_stalled", N*W'(swap_count), N*W'(2));
    s_axis_coeff_tvalid = 1'b0;
    data_tvalid = 1'b0; data_tlast = 1'b0;
    expect_swap(300, 3);
    dbeat(1'b1);
    chk("t4_vector_swapped", coeff_vector, mkvec(300));

    // Swap counter wrap-around over many loads.
    for (int i = 4; i <= 257; i++) begin
      send(N, i * 3, 1'b0);
      expect_swap(i * 3, i);
      dbeat(1'b1);
    end
    chk("t_wrap", N*W'(swap_count), N*W'(1));

    // Asynchronous reset in the middle of a load, with an error pending.
    send(5, 700, 1'b0);
    send(7, 800, 1'b0);
    s_axis_coeff_tdata = 16'h0807; s_axis_coeff_tvalid = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("t5_vector", coeff_vector, '0);
    chk("t5_pending", N*W'(coeff_pending), '0);
    chk("t5_error", N*W'(load_error), '0);
    chk("t5_swap_count", N*W'(swap_count), '0);
    chk("t5_tready", N*W'(s_axis_coeff_tready), N*W'(1));
    s_axis_coeff_tvalid = 1'b0;
    exp_active = '0;
    repeat (2) @(posedge aclk);
    #1 reset = 1'b0;
    @(posedge aclk); #1;
    send(N, 900, 1'b0);
    expect_swap(900, 1);
    dbeat(1'b1);
`endif

    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge aclk);
      t++;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain outstanding=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
